// File: rtl/word_serializer.sv
// Parallel-in, serial-out word serializer: MSB first, one bit per clk, frame strobe on each MSB.
// Define SERIALIZER_PARITY_EN to append an even-parity slot after every word.
module word_serializer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame,
  output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int SLOTS = WIDTH + 1;
`else
  localparam int SLOTS = WIDTH;
`endif
  localparam int CNT_W = ($clog2(SLOTS + 1) < 1) ? 1 : $clog2(SLOTS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SLOTS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_q, frame_d;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic             accept;

  // A new word may load either from IDLE or on the last slot of the current word.
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0)));
  assign accept    = in_valid && in_ready;
  assign busy      = !rst && (state_q == SHIFT);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign frame     = frame_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    frame_d     = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    if (accept) begin
      out_d       = in_data[WIDTH-1];
      out_valid_d = 1'b1;
      frame_d     = 1'b1;
      shreg_d     = in_data << 1;
      cnt_d       = CNT_LOAD;
      state_d     = SHIFT;
`ifdef SERIALIZER_PARITY_EN
      parity_d    = ^in_data;
`endif
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
`ifdef SERIALIZER_PARITY_EN
        // One slot left means the data bits are exhausted and parity goes out.
        out_d = (cnt_q == CNT_W'(1)) ? parity_q : shreg_q[WIDTH-1];
`else
        out_d = shreg_q[WIDTH-1];
`endif
        out_valid_d = 1'b1;
        shreg_d     = shreg_q << 1;
        cnt_d       = cnt_q - CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      frame_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      frame_q     <= frame_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule
